// File: rtl/sd_block_arbiter_if.sv
// -----------------------------------------------------------------------------
// sd_block_arbiter_if
//   Bundles the client-side request wiring and the host SD block interface
//   that sd_block_arbiter sits between.
//
//   Client side (one lane per client, client i in lane i):
//     client_lba       32*N  block address requested by each client
//     client_rd        N     read request level per client
//     client_wr        N     write request level per client
//     client_buff_din  8*N   write data from each client toward SD
//     client_ack       N     host_ack routed back to the granted client
//   Host side:
//     host_lba         32    latched LBA of the granted request
//     host_rd          1     read strobe to host
//     host_wr          1     write strobe to host
//     host_ack         1     host acknowledge, high for the whole transfer
//     host_buff_din    8     write data of the granted client
//   Status:
//     grant            N     one-hot current owner
//     timeout_err      1     one-cycle pulse on watchdog abort
//
//   master : the arbiter's view
//   slave  : the view of the surrounding clients/host
// -----------------------------------------------------------------------------
interface sd_block_arbiter_if #(
  parameter int NUM_CLIENTS = 3
);
  logic [32*NUM_CLIENTS-1:0] client_lba;
  logic [NUM_CLIENTS-1:0]    client_rd;
  logic [NUM_CLIENTS-1:0]    client_wr;
  logic [8*NUM_CLIENTS-1:0]  client_buff_din;
  logic [NUM_CLIENTS-1:0]    client_ack;
  logic [31:0]               host_lba;
  logic                      host_rd;
  logic                      host_wr;
  logic                      host_ack;
  logic [7:0]                host_buff_din;
  logic [NUM_CLIENTS-1:0]    grant;
  logic                      timeout_err;

  modport master (
    input  client_lba, client_rd, client_wr, client_buff_din, host_ack,
    output client_ack, host_lba, host_rd, host_wr, host_buff_din, grant,
           timeout_err
  );

  modport slave (
    output client_lba, client_rd, client_wr, client_buff_din, host_ack,
    input  client_ack, host_lba, host_rd, host_wr, host_buff_din, grant,
           timeout_err
  );
endinterface

// File: rtl/sd_block_arbiter.sv
// -----------------------------------------------------------------------------
// sd_block_arbiter
//   Serialises the block requests of NUM_CLIENTS clients (0 = floppy 1,
//   1 = HDD, 2 = floppy 2) onto the single host SD block interface.
//   Clients are granted one at a time in round-robin order; the granted
//   client's LBA and direction are latched, host_ack and write data are routed
//   to/from that client only, and a watchdog aborts requests the host never
//   acknowledges.
//
//   Ports:
//     clk_sys  in   system clock
//     reset    in   synchronous active-high reset, overrides everything
//     bus      master modport of sd_block_arbiter_if (client and host lanes,
//              grant and timeout_err)
//
//   Parameters:
//     NUM_CLIENTS  number of requesting clients
//     TIMEOUT      clk_sys cycles allowed in REQ before the request is aborted
// -----------------------------------------------------------------------------
module sd_block_arbiter #(
  parameter int          NUM_CLIENTS = 3,
  parameter logic [23:0] TIMEOUT     = 24'd10_000_000
) (
  input logic                clk_sys,
  input logic                reset,
  sd_block_arbiter_if.master bus
);

  localparam int PTR_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  // One extra bit so rr_ptr + offset can be wrapped without overflow.
  localparam int IDX_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_DONE
  } state_t;

  // Registered state
  state_t                 state_q;
  logic [PTR_W-1:0]       rr_ptr_q;
  logic [NUM_CLIENTS-1:0] grant_q;
  logic [31:0]            host_lba_q;
  logic                   host_rd_q;
  logic                   host_wr_q;
  logic                   timeout_err_q;
  logic                   old_ack_q;
  logic [23:0]            wdog_q;

  // Arbitration results for the current cycle
  logic [NUM_CLIENTS-1:0] pend;
  logic                   any_pend;
  logic [IDX_W-1:0]       scan_idx;
  logic [PTR_W-1:0]       sel_d;
  logic [PTR_W-1:0]       rr_ptr_d;
  logic [NUM_CLIENTS-1:0] grant_d;
  logic [31:0]            lba_d;
  logic                   rd_sel;
  logic                   wr_sel;

  logic                   ack_rise;
  logic                   ack_fall;
  logic [7:0]             buff_mux;

  assign ack_rise = bus.host_ack & ~old_ack_q;
  assign ack_fall = ~bus.host_ack & old_ack_q;

  // Round-robin search: offsets are scanned from the far end back toward
  // rr_ptr so the closest pending client (smallest offset) is written last
  // and therefore wins.
  always_comb begin
    pend     = bus.client_rd | bus.client_wr;
    sel_d    = '0;
    scan_idx = '0;
    for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
      scan_idx = {1'b0, rr_ptr_q} + IDX_W'(k);
      if (scan_idx >= IDX_W'(NUM_CLIENTS)) begin
        scan_idx = scan_idx - IDX_W'(NUM_CLIENTS);
      end
      if (pend[scan_idx[PTR_W-1:0]]) begin
        sel_d = scan_idx[PTR_W-1:0];
      end
    end
  end

  assign any_pend = |pend;

  // Per-client fields of the selected client, and its one-hot grant.
  always_comb begin
    lba_d   = '0;
    rd_sel  = 1'b0;
    wr_sel  = 1'b0;
    grant_d = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (sel_d == PTR_W'(i)) begin
        lba_d      = bus.client_lba[32*i +: 32];
        rd_sel     = bus.client_rd[i];
        wr_sel     = bus.client_wr[i];
        grant_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    if (sel_d == PTR_W'(NUM_CLIENTS - 1)) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = sel_d + 1'b1;
    end
  end

  // Write-data mux; grant is one-hot or zero, so OR-ing the lanes is exact
  // and yields 0 when nobody owns the bus.
  always_comb begin
    buff_mux = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (grant_q[i]) begin
        buff_mux = buff_mux | bus.client_buff_din[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      host_lba_q    <= '0;
      host_rd_q     <= 1'b0;
      host_wr_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      old_ack_q     <= 1'b0;
      wdog_q        <= '0;
    end else begin
      old_ack_q     <= bus.host_ack;
      timeout_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_pend) begin
            grant_q    <= grant_d;
            host_lba_q <= lba_d;
            rr_ptr_q   <= rr_ptr_d;
            // Read wins when both levels are up; the write stays pending
            // and is picked up on a later grant.
            host_rd_q  <= rd_sel;
            host_wr_q  <= wr_sel & ~rd_sel;
            wdog_q     <= '0;
            state_q    <= S_REQ;
          end
        end

        S_REQ: begin
          // An ack already high on entry is not an edge: old_ack_q is high
          // too, so we wait for a fresh low-to-high transition.
          if (ack_rise) begin
            host_rd_q <= 1'b0;
            host_wr_q <= 1'b0;
            state_q   <= S_XFER;
          end else if (wdog_q == TIMEOUT - 24'd1) begin
            host_rd_q     <= 1'b0;
            host_wr_q     <= 1'b0;
            grant_q       <= '0;
            timeout_err_q <= 1'b1;
            state_q       <= S_IDLE;
          end else begin
            wdog_q <= wdog_q + 24'd1;
          end
        end

        S_XFER: begin
          if (ack_fall) begin
            state_q <= S_DONE;
          end
        end

        S_DONE: begin
          // One idle cycle lets the client drop its level before the next
          // arbitration, so a still-held request is not granted twice.
          grant_q <= '0;
          state_q <= S_IDLE;
        end

        default: begin
          grant_q   <= '0;
          host_rd_q <= 1'b0;
          host_wr_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.grant         = grant_q;
  assign bus.host_lba      = host_lba_q;
  assign bus.host_rd       = host_rd_q;
  assign bus.host_wr       = host_wr_q;
  assign bus.timeout_err   = timeout_err_q;
  assign bus.host_buff_din = buff_mux;
  assign bus.client_ack    = grant_q & {NUM_CLIENTS{bus.host_ack}};

  // Structural invariants of the arbiter outputs.
  grant_onehot0_a: assert property (@(posedge clk_sys) $onehot0(grant_q));
  single_dir_a: assert property (@(posedge clk_sys) !(host_rd_q && host_wr_q));

endmodule

// File: tb/tb_sd_block_arbiter.sv
module tb_sd_block_arbiter;
  localparam int N = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sd_block_arbiter_if #(.NUM_CLIENTS(N)) bus ();

  sd_block_arbiter #(
    .NUM_CLIENTS(N),
    .TIMEOUT    (24'd16)
  ) dut (
    .clk_sys(clk),
    .reset  (reset),
    .bus    (bus.master)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Client-side stimulus state kept by the bench
  logic [N-1:0] rd_v;
  logic [N-1:0] wr_v;
  logic [31:0]  lba_a [N];
  logic [7:0]   dat_a [N];
  // Reference model: next client index to start the round-robin search from
  int           rr_m;

  typedef struct {
    logic [N-1:0] rd;
    logic [N-1:0] wr;
    int           d;
    int           len;
    logic [N-1:0] eg;
    logic         erd;
    logic         ewr;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.client_lba[32*i +: 32]     = lba_a[i];
      bus.client_buff_din[8*i +: 8]  = dat_a[i];
    end
    bus.client_rd = rd_v;
    bus.client_wr = wr_v;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // First pending client found scanning rr_m, rr_m+1, ... modulo N.
  function automatic int pick();
    int i;
    for (int k = 0; k < N; k++) begin
      i = (rr_m + k) % N;
      if (rd_v[i] | wr_v[i]) return i;
    end
    return -1;
  endfunction

  // One complete host transaction. Called during a cycle in which the arbiter
  // is idle and the client levels for the next arbitration are already driven.
  // d <= 15: host raises ack d cycles after the strobe appears and holds it
  // for len cycles (len >= 2). d > 15: host never acks, watchdog expires.
  // Returns during the next cycle in which the arbiter is idle again.
  task automatic run_txn(input string tag, input int d, input int len,
                         input logic [N-1:0] eg, input logic erd, input logic ewr);
    int          s;
    logic [31:0] elba;
    logic [7:0]  edat;
    s = 0;
    for (int i = 0; i < N; i++) if (eg[i]) s = i;
    elba = lba_a[s];
    edat = dat_a[s];
    rr_m = (s + 1) % N;

    next_cycle();  // strobe cycle g
    lba_a[s] = $urandom;  // must not disturb the latched host_lba
    drive();
    #1;
    chk({tag, " grant"}, 32'(bus.grant), 32'(eg));
    chk({tag, " host_lba"}, bus.host_lba, elba);
    chk({tag, " rd/wr"}, {30'd0, bus.host_rd, bus.host_wr}, {30'd0, erd, ewr});
    chk({tag, " buff_din"}, 32'(bus.host_buff_din), 32'(edat));
    chk({tag, " tmo/ack quiet"}, {30'd0, bus.timeout_err, |bus.client_ack}, 32'd0);

    if (d <= 15) begin
      for (int j = 1; j < d; j++) begin
        next_cycle(); #1;
        chk({tag, " hold"}, {30'd0, bus.host_rd, bus.host_wr}, {30'd0, erd, ewr});
      end
      next_cycle();  // g+d
      bus.host_ack = 1'b1;
      #1;
      chk({tag, " client_ack"}, 32'(bus.client_ack), 32'(eg));
      next_cycle();  // g+d+1: client drops the serviced direction
      if (erd) rd_v[s] = 1'b0;
      else     wr_v[s] = 1'b0;
      drive();
      #1;
      chk({tag, " strobe clr"}, {30'd0, bus.host_rd, bus.host_wr}, 32'd0);
      chk({tag, " grant xfer"}, 32'(bus.grant), 32'(eg));
      for (int j = 2; j < len; j++) begin
        next_cycle(); #1;
        chk({tag, " ack route"}, 32'(bus.client_ack), 32'(eg));
        chk({tag, " buff xfer"}, 32'(bus.host_buff_din), 32'(edat));
      end
      next_cycle();  // F: ack falls
      bus.host_ack = 1'b0;
      #1;
      chk({tag, " ack low"}, 32'(bus.client_ack), 32'd0);
      next_cycle(); #1;  // F+1
      chk({tag, " grant done"}, 32'(bus.grant), 32'(eg));
      next_cycle(); #1;  // F+2
      chk({tag, " grant rel"}, 32'(bus.grant), 32'd0);
      chk({tag, " buff idle"}, 32'(bus.host_buff_din), 32'd0);
      chk({tag, " lba kept"}, bus.host_lba, elba);
    end else begin
      for (int j = 1; j < 16; j++) begin
        next_cycle(); #1;
        chk({tag, " hold"}, {30'd0, bus.host_rd, bus.host_wr}, {30'd0, erd, ewr});
        chk({tag, " no tmo"}, 32'(bus.timeout_err), 32'd0);
      end
      next_cycle(); #1;  // g+16
      chk({tag, " tmo pulse"}, 32'(bus.timeout_err), 32'd1);
      chk({tag, " tmo rd/wr"}, {30'd0, bus.host_rd, bus.host_wr}, 32'd0);
      chk({tag, " tmo grant"}, 32'(bus.grant), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no end, required finish");
    $fatal(1, "time limit");
  end

  initial begin
    int           s;
    int           dir;
    logic [N-1:0] eg;

    // Vectors in the order applied; each row's expectation follows from the
    // round-robin rule applied to the pending set left by the previous rows.
    tbl[0] = '{3'b111, 3'b000, 3, 4,   3'b001, 1'b1, 1'b0};  // round robin
    tbl[1] = '{3'b111, 3'b000, 2, 3,   3'b010, 1'b1, 1'b0};
    tbl[2] = '{3'b111, 3'b000, 1, 2,   3'b100, 1'b1, 1'b0};
    tbl[3] = '{3'b111, 3'b000, 2, 5,   3'b001, 1'b1, 1'b0};
    tbl[4] = '{3'b010, 3'b000, 4, 512, 3'b010, 1'b1, 1'b0};  // single read
    tbl[5] = '{3'b100, 3'b100, 3, 4,   3'b100, 1'b1, 1'b0};  // rd+wr, read wins
    tbl[6] = '{3'b000, 3'b000, 2, 3,   3'b100, 1'b0, 1'b1};  // leftover write
    tbl[7] = '{3'b000, 3'b001, 5, 20,  3'b001, 1'b0, 1'b1};  // write data mux
    tbl[8] = '{3'b001, 3'b000, 99, 2,  3'b001, 1'b1, 1'b0};  // timeout
    tbl[9] = '{3'b010, 3'b000, 15, 3,  3'b010, 1'b1, 1'b0};  // ack on last REQ cycle

    reset        = 1'b1;
    bus.host_ack = 1'b0;
    rd_v         = '0;
    wr_v         = '0;
    lba_a[0]     = 32'h1000_0A00;
    lba_a[1]     = 32'h0000_0123;
    lba_a[2]     = 32'h2000_0C00;
    dat_a[0]     = 8'hA5;
    dat_a[1]     = 8'h5A;
    dat_a[2]     = 8'h3C;
    rr_m         = 0;
    drive();
    repeat (3) next_cycle();
    #1;
    chk("reset grant", 32'(bus.grant), 32'd0);
    chk("reset rd/wr/tmo", {29'd0, bus.host_rd, bus.host_wr, bus.timeout_err}, 32'd0);
    chk("reset lba", bus.host_lba, 32'd0);
    chk("reset buff", 32'(bus.host_buff_din), 32'd0);
    reset = 1'b0;

    for (int r = 0; r < 10; r++) begin
      rd_v = rd_v | tbl[r].rd;
      wr_v = wr_v | tbl[r].wr;
      drive();
      run_txn($sformatf("vec%0d", r), tbl[r].d, tbl[r].len, tbl[r].eg, tbl[r].erd, tbl[r].ewr);
    end

    // Reset while client 1 is mid-transfer with host_ack high.
    rd_v = 3'b010;
    wr_v = 3'b000;
    drive();
    next_cycle(); #1;
    chk("rst-seq grant", 32'(bus.grant), 32'b010);
    next_cycle();
    bus.host_ack = 1'b1;
    next_cycle(); #1;
    chk("rst-seq xfer ack", 32'(bus.client_ack), 32'b010);
    reset = 1'b1;
    next_cycle(); #1;
    chk("rst-seq grant", 32'(bus.grant), 32'd0);
    chk("rst-seq client_ack", 32'(bus.client_ack), 32'd0);
    chk("rst-seq outs", {29'd0, bus.host_rd, bus.host_wr, bus.timeout_err}, 32'd0);
    chk("rst-seq lba", bus.host_lba, 32'd0);
    chk("rst-seq buff", 32'(bus.host_buff_din), 32'd0);
    reset        = 1'b0;
    bus.host_ack = 1'b0;
    rd_v         = 3'b101;
    drive();
    rr_m = 0;
    run_txn("post-reset", 3, 2, 3'b001, 1'b1, 1'b0);

    // Randomised traffic against the round-robin reference model.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!(rd_v[i] | wr_v[i]) && ($urandom_range(0, 1) == 1)) begin
          dir      = int'($urandom_range(1, 3));
          rd_v[i]  = dir[0];
          wr_v[i]  = dir[1];
          lba_a[i] = $urandom;
          dat_a[i] = 8'($urandom);
        end
      end
      if ((rd_v | wr_v) == '0) rd_v[t % N] = 1'b1;
      drive();
      s  = pick();
      eg = '0;
      eg[s] = 1'b1;
      run_txn($sformatf("rand%0d", t), int'($urandom_range(1, 17)), int'($urandom_range(2, 20)),
              eg, rd_v[s], wr_v[s] & ~rd_v[s]);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/sd_block_arbiter.md
Name: sd_block_arbiter

Overview:
- Arbitrates the single host SD block interface between NUM_CLIENTS block-device clients: floppy track 1, HDD sector engine and floppy track 2.
- Sits directly downstream of the floppy_track instances and the HDD request handshake. It replaces their per-client sd_rd/sd_wr/sd_ack wiring with one serialized host transaction stream.
- Grants one client at a time in round-robin order and latches that client's LBA and direction.
- Routes host_ack and host_buff_din to and from the granted client only. Adds a request watchdog.

Parameters:
- NUM_CLIENTS, 3, number of requesting clients; index 0 = floppy 1, 1 = HDD, 2 = floppy 2.
- TIMEOUT, 24'd10_000_000, clk_sys cycles allowed in REQ before a request is aborted.

Ports:
- clk_sys  in  1  system clock (14 MHz).
- reset  in  1  synchronous, active-high reset.
- client_lba  in  32*NUM_CLIENTS  per-client block address; client i occupies bits [32i+31:32i].
- client_rd  in  NUM_CLIENTS  per-client read request level, held until that client's ack rises.
- client_wr  in  NUM_CLIENTS  per-client write request level, held until that client's ack rises.
- client_buff_din  in  8*NUM_CLIENTS  per-client write data toward SD.
- client_ack  out  NUM_CLIENTS  host_ack routed to the granted client; 0 for all others.
- host_lba  out  32  latched LBA of the granted request.
- host_rd  out  1  read strobe to host.
- host_wr  out  1  write strobe to host.
- host_ack  in  1  host acknowledge; high for the whole transfer.
- host_buff_din  out  8  client_buff_din of the granted client; 0 when idle.
- grant  out  NUM_CLIENTS  one-hot current owner; 0 in IDLE.
- timeout_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (synchronous, active-high, overrides any state including mid-transfer):
  - state=IDLE; rr_ptr=0; all outputs 0.
  - A client mid-transfer sees client_ack drop to 0 immediately.
- Pending vector: pend[i] = client_rd[i] | client_wr[i].
- IDLE:
  - If any pend bit is set, select the first set bit searching rr_ptr, rr_ptr+1, …, wrapping modulo NUM_CLIENTS.
  - On the same edge: grant <= onehot(sel); host_lba <= client_lba[sel]; rr_ptr <= sel+1 mod NUM_CLIENTS; state <= REQ.
  - Direction: host_rd <= client_rd[sel]; host_wr <= client_wr[sel] & ~client_rd[sel]. Read wins when both are set; the write is serviced on a later grant.
  - Grant latency: request asserted at cycle n → host_rd/host_wr high at n+1.
- REQ:
  - host_rd/host_wr held. Watchdog counter increments each cycle.
  - On the rising edge of host_ack (registered old_ack=0, host_ack=1): clear host_rd/host_wr; state <= XFER.
  - If the counter reaches TIMEOUT-1 with no ack: clear host_rd/host_wr and grant; pulse timeout_err for 1 cycle; state <= IDLE. rr_ptr has already advanced.
- XFER:
  - Waits for the falling edge of host_ack (old_ack=1, host_ack=0), then state <= DONE.
  - No timeout in XFER.
- DONE:
  - One cycle: grant <= 0; state <= IDLE.
  - Gives the client one clk to drop its request level before re-arbitration, so a held level is not double-granted.
- client_ack (combinational): client_ack[i] = host_ack & grant[i]. Host ack bits for non-granted clients are never asserted.
- host_buff_din (combinational): mux of client_buff_din by grant; 0 when grant=0.
- host_lba is stable from grant until the next grant; client_lba changes after grant are ignored.
- A request that deasserts during REQ does not abort the host transaction. The arbiter completes it and discards ownership normally.
- A host_ack already high on entry to REQ is not an edge; the arbiter waits for it to fall and rise again.
- Watchdog is 24 bits and cleared on every IDLE→REQ transition.

Test Plan:
- Single read: client 1 rd=1, lba=0x0000_0123 at cycle 10. Host acks at 15 for 512 cycles.
  - Required: host_rd=1 and host_lba=0x123 at 11; host_rd=0 at 16; client_ack=3'b010 during ack; grant=0 two cycles after ack falls.
- Round robin: clients 0, 1 and 2 all request reads continuously.
  - Required: grant order 001, 010, 100, 001; each client served once per rotation.
- rd and wr both set on client 2.
  - Required: host_rd=1, host_wr=0.
  - After completion, client 2 holds wr only → the next grant of client 2 issues host_wr=1.
- Write data mux: client 0 write with client_buff_din[7:0]=0xA5, client 2 driving 0x3C.
  - Required: host_buff_din=0xA5 throughout; 0x00 after DONE.
- Timeout: TIMEOUT=16, client 0 rd, host never acks.
  - Required: host_rd drops and timeout_err pulses exactly 16 cycles after grant; the next pending client (1) is granted afterwards.
- Reset mid-XFER: assert reset while host_ack=1 for client 1.
  - Required: next cycle all outputs 0, state IDLE; after reset, a client 0 request is granted first (rr_ptr=0).
